mem_port_arbiter: RTL and testbench

- Shares the single PSRAM data port (ramData) between two requesters: the CPU data path (requester 0) and a DMA/PPU framebuffer fetch engine (requester 1).
- Sits between the bus and ramData, with round-robin grant and registered command issue.
- Adds a completion timeout so a hung memory transaction cannot stall the CPU forever.

---
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single PSRAM data port between the CPU data path (requester 0)
//   and the DMA/PPU framebuffer fetch engine (requester 1). Round-robin grant,
//   registered command issue, and a completion timeout so a hung memory op
//   cannot stall a requester forever.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   rN_req/wen/addr/    requester N command (req is a level held until ack)
//   rN_wdata/bsel
//   rN_rdata, rN_ack    read data and one-cycle completion pulse
//   mem_ren/mem_wen     one-cycle command pulses to the memory controller
//   mem_addr/wdata/bsel registered command, stable from issue until next grant
//   mem_rdata, mem_done memory read data and completion pulse
//   busy                any state other than IDLE
//   grant               owner of the current/last transaction (0=CPU, 1=DMA)
//   timeout_err         sticky timeout flag, cleared only by reset
module mem_port_arbiter #(
    parameter int          ADDR_W   = 32,
    parameter int          TIMEOUT  = 1023,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_wen,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [31:0]       r0_wdata,
    input  logic [3:0]        r0_bsel,
    output logic [31:0]       r0_rdata,
    output logic              r0_ack,
    input  logic              r1_req,
    input  logic              r1_wen,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [31:0]       r1_wdata,
    input  logic [3:0]        r1_bsel,
    output logic [31:0]       r1_rdata,
    output logic              r1_ack,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_bsel,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_done,
    output logic              busy,
    output logic              grant,
    output logic              timeout_err
);

    // Counter only has to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state, state_nx;
    logic             last_grant;
    logic [CNT_W-1:0] cnt;
    logic             take;      // new grant this cycle
    logic             pick;      // requester selected by arbitration
    logic             tmo;       // timeout fires this cycle
    logic             tmo_hit;
    logic             sel_wen;

    assign busy    = (state != IDLE);
    assign tmo_hit = (TIMEOUT != 0) && (int'(cnt) == TIMEOUT - 1);
    assign sel_wen = pick ? r1_wen : r0_wen;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        take     = 1'b0;
        pick     = 1'b0;
        tmo      = 1'b0;
        case (state)
            IDLE: begin
                if (r0_req || r1_req) begin
                    take     = 1'b1;
                    // On a tie the requester that did not own the last slot wins.
                    pick     = (r0_req && r1_req) ? ~last_grant : r1_req;
                    state_nx = ISSUE;
                end
            end
            ISSUE: state_nx = WAIT;
            WAIT: begin
                // A done in the timeout cycle takes priority over the timeout.
                if (mem_done) begin
                    state_nx = RESP;
                end else if (tmo_hit) begin
                    tmo      = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant  <= 1'b1;
            grant       <= 1'b0;
            cnt         <= '0;
            mem_ren     <= 1'b0;
            mem_wen     <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_bsel    <= '0;
            r0_ack      <= 1'b0;
            r1_ack      <= 1'b0;
            r0_rdata    <= '0;
            r1_rdata    <= '0;
            timeout_err <= 1'b0;
        end else begin
            mem_ren <= 1'b0;
            mem_wen <= 1'b0;
            r0_ack  <= 1'b0;
            r1_ack  <= 1'b0;

            // Command registers and pulses set on grant; pulses are high during ISSUE.
            if (take) begin
                grant      <= pick;
                last_grant <= pick;
                mem_addr   <= pick ? r1_addr  : r0_addr;
                mem_wdata  <= pick ? r1_wdata : r0_wdata;
                mem_bsel   <= pick ? r1_bsel  : r0_bsel;
                mem_ren    <= ~sel_wen;
                mem_wen    <= sel_wen;
            end

            if (state == ISSUE) cnt <= '0;

            // Ack and rdata are loaded on the WAIT->RESP edge so they are
            // visible during the RESP cycle.
            if (state == WAIT) begin
                if (mem_done || tmo) begin
                    if (grant) begin
                        r1_ack   <= 1'b1;
                        r1_rdata <= mem_done ? mem_rdata : ERR_DATA;
                    end else begin
                        r0_ack   <= 1'b1;
                        r0_rdata <= mem_done ? mem_rdata : ERR_DATA;
                    end
                    if (!mem_done) timeout_err <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT=16). Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
module tb_mem_port_arbiter;

    logic        clk, reset;
    logic        r0_req, r0_wen, r1_req, r1_wen;
    logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
    logic [3:0]  r0_bsel, r1_bsel;
    logic [31:0] r0_rdata, r1_rdata;
    logic        r0_ack, r1_ack;
    logic        mem_ren, mem_wen, mem_done, busy, grant, timeout_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_bsel;

    // memory model: manual drive or auto responder
    logic        auto_en, hang, auto_done, man_done;
    logic [31:0] auto_rd, man_rd;
    int          lat, cd;

    int total, bad;
    int ren_n, r1_ack_n;

    assign mem_done  = man_done | auto_done;
    assign mem_rdata = auto_en ? auto_rd : man_rd;

    mem_port_arbiter #(.ADDR_W(32), .TIMEOUT(16), .ERR_DATA(32'hDEADBEEF)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_wen(r0_wen), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_bsel(r0_bsel), .r0_rdata(r0_rdata), .r0_ack(r0_ack),
        .r1_req(r1_req), .r1_wen(r1_wen), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_bsel(r1_bsel), .r1_rdata(r1_rdata), .r1_ack(r1_ack),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_bsel(mem_bsel), .mem_rdata(mem_rdata),
        .mem_done(mem_done), .busy(busy), .grant(grant), .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Auto responder: mem_done 'lat' cycles after the command pulse.
    always @(posedge clk) begin
        #1;
        auto_done = 1'b0;
        if (!auto_en) cd = 0;
        else begin
            if (cd > 0) begin
                cd--;
                if (cd == 0) auto_done = 1'b1;
            end
            if ((mem_ren || mem_wen) && !hang) cd = lat;
        end
    end

    always @(negedge clk) begin
        if (mem_ren) ren_n++;
        if (r1_ack)  r1_ack_n++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        r0_req = 0; r1_req = 0; man_done = 0;
        step; step;
        reset = 1'b1;
        step;
    endtask

    task automatic wait_cmd;
        bit ok;
        ok = 0;
        for (int n = 0; n < 20; n++) begin
            step;
            if (mem_ren || mem_wen) begin
                ok = 1;
                break;
            end
        end
        chk("cmd_seen", 64'(ok), 64'd1);
    endtask

    task automatic wait_ack(input logic who);
        bit ok;
        ok = 0;
        for (int n = 0; n < 40; n++) begin
            step;
            if ((who == 1'b0 && r0_ack) || (who == 1'b1 && r1_ack)) begin
                ok = 1;
                break;
            end
        end
        chk("ack_seen", 64'(ok), 64'd1);
    endtask

    initial begin
        total = 0; bad = 0; ren_n = 0; r1_ack_n = 0;
        auto_en = 0; hang = 0; lat = 1; cd = 0; auto_done = 0; auto_rd = 0;
        man_done = 0; man_rd = 0;
        r0_req = 0; r0_wen = 0; r0_addr = 0; r0_wdata = 0; r0_bsel = 4'hF;
        r1_req = 0; r1_wen = 0; r1_addr = 0; r1_wdata = 0; r1_bsel = 4'hF;
        reset = 1'b1;
        #2;
        do_reset;

        // reset state
        chk("rst_busy",  64'(busy), 0);
        chk("rst_grant", 64'(grant), 0);
        chk("rst_ren",   64'(mem_ren | mem_wen), 0);
        chk("rst_addr",  64'(mem_addr), 0);
        chk("rst_acks",  64'({r0_ack, r1_ack}), 0);
        chk("rst_terr",  64'(timeout_err), 0);
        chk("rst_rdata", 64'(r0_rdata | r1_rdata), 0);

        // single CPU read, mem_done 4 cycles after mem_ren
        ren_n = 0; r1_ack_n = 0;
        r0_addr = 32'h100; r0_wen = 0; r0_req = 1;
        step;
        chk("rd_ren",   64'(mem_ren), 1);
        chk("rd_wen",   64'(mem_wen), 0);
        chk("rd_addr",  64'(mem_addr), 64'h100);
        chk("rd_busy",  64'(busy), 1);
        chk("rd_grant", 64'(grant), 0);
        for (int k = 2; k <= 4; k++) begin
            step;
            chk($sformatf("rd_noack%0d", k), 64'(r0_ack), 0);
        end
        step;
        man_done = 1; man_rd = 32'h12345678;
        chk("rd_noack5", 64'(r0_ack), 0);
        step;
        man_done = 0;
        chk("rd_ack",   64'(r0_ack), 1);
        chk("rd_data",  64'(r0_rdata), 64'h12345678);
        r0_req = 0;
        step;
        chk("rd_ack_end", 64'(r0_ack), 0);
        chk("rd_idle",    64'(busy), 0);
        chk("rd_ren_n",   64'(ren_n), 1);
        chk("rd_r1ack_n", 64'(r1_ack_n), 0);

        // simultaneous requests after reset, 8 alternating transactions
        do_reset;
        auto_en = 1; hang = 0; lat = 1; auto_rd = 32'h0BADF00D;
        r0_wen = 1; r0_addr = 32'h10; r0_wdata = 32'hAABBCCDD; r0_bsel = 4'hF;
        r1_wen = 0; r1_addr = 32'h20;
        r0_req = 1; r1_req = 1;
        for (int i = 0; i < 8; i++) begin
            wait_cmd;
            chk($sformatf("alt_grant%0d", i), 64'(grant), 64'(i & 1));
            if (i == 0) begin
                chk("alt0_wen",   64'(mem_wen), 1);
                chk("alt0_wdata", 64'(mem_wdata), 64'hAABBCCDD);
                chk("alt0_addr",  64'(mem_addr), 64'h10);
            end
            if (i == 1) begin
                chk("alt1_ren",  64'(mem_ren), 1);
                chk("alt1_addr", 64'(mem_addr), 64'h20);
            end
            wait_ack(1'(i & 1));
        end
        r0_req = 0; r1_req = 0;
        step; step;

        // timeout: r1 read, memory never answers
        hang = 1;
        r1_wen = 0; r1_addr = 32'h40; r1_req = 1;
        wait_cmd;
        step;   // first WAIT cycle
        for (int k = 1; k <= 15; k++) begin
            step;
            chk($sformatf("to_noack%0d", k), 64'(r1_ack), 0);
        end
        step;
        chk("to_ack",   64'(r1_ack), 1);
        chk("to_data",  64'(r1_rdata), 64'hDEADBEEF);
        chk("to_err",   64'(timeout_err), 1);
        r1_req = 0;
        hang = 0; lat = 2; auto_rd = 32'h11112222;
        step;
        r0_wen = 0; r0_addr = 32'h80; r0_req = 1;
        wait_cmd;
        wait_ack(1'b0);
        r0_req = 0;
        chk("to_good_data", 64'(r0_rdata), 64'h11112222);
        chk("to_err_stick", 64'(timeout_err), 1);
        chk("to_r1_hold",   64'(r1_rdata), 64'hDEADBEEF);
        step;
        auto_en = 0;

        // mem_done coincides with the timeout cycle
        do_reset;
        r0_wen = 0; r0_addr = 32'h200; r0_req = 1;
        step;   // ISSUE
        step;   // first WAIT cycle
        r0_req = 0;
        for (int k = 1; k <= 14; k++) step;
        step;
        man_done = 1; man_rd = 32'h5A5A5A5A;
        chk("co_noack", 64'(r0_ack), 0);
        step;
        man_done = 0;
        chk("co_ack",  64'(r0_ack), 1);
        chk("co_data", 64'(r0_rdata), 64'h5A5A5A5A);
        chk("co_err",  64'(timeout_err), 0);
        step;
        chk("co_idle", 64'(busy), 0);

        // withdrawal after issue, then a stray done while idle
        r0_wen = 1; r0_addr = 32'h300; r0_wdata = 32'h55; r0_bsel = 4'h3; r0_req = 1;
        step;
        chk("wd_wen",  64'(mem_wen), 1);
        chk("wd_bsel", 64'(mem_bsel), 64'h3);
        step;
        r0_req = 0;
        step; step;
        chk("wd_addr_stable", 64'(mem_addr), 64'h300);
        man_done = 1;
        step;
        man_done = 0;
        chk("wd_ack", 64'(r0_ack), 1);
        step;
        chk("wd_idle", 64'(busy), 0);
        man_done = 1;
        step;
        man_done = 0;
        chk("stray_ack",  64'({r0_ack, r1_ack}), 0);
        chk("stray_busy", 64'(busy), 0);
        step;
        chk("stray_ack2", 64'({r0_ack, r1_ack}), 0);
        chk("stray_addr", 64'(mem_addr), 64'h300);

        // asynchronous reset in the middle of WAIT
        r0_wen = 0; r0_addr = 32'h400; r0_req = 1;
        step;
        step;
        chk("ar_busy_pre", 64'(busy), 1);
        #3;
        reset = 1'b0;
        #1;
        chk("ar_busy",  64'(busy), 0);
        chk("ar_addr",  64'(mem_addr), 0);
        chk("ar_cmd",   64'({mem_ren, mem_wen}), 0);
        chk("ar_acks",  64'({r0_ack, r1_ack}), 0);
        chk("ar_grant", 64'(grant), 0);
        r0_req = 0;
        step; step;
        reset = 1'b1;
        r0_addr = 32'h10; r1_wen = 0; r1_addr = 32'h20;
        r0_req = 1; r1_req = 1;
        step;
        chk("ar_tie_grant", 64'(grant), 0);
        chk("ar_tie_ren",   64'(mem_ren), 1);
        chk("ar_tie_addr",  64'(mem_addr), 64'h10);
        r0_req = 0; r1_req = 0;
        step;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
